aer_event_encoder: RTL and testbench
====================================

# aer_event_encoder

Clocked encoder downstream of the row/column interface cells of the spike-encoder array. It samples the one-hot acknowledge vectors (`s`) of all row and column interfaces and encodes them into a row/column address. It timestamps each event, buffers it in a small FIFO and drives a 4-phase req/ack handshake to the off-chip AER receiver. It also produces the `arbtop_n_ri` hold-off signal that the row/column interfaces use to gate new requests.

## Interface
Parameters:
- `NROW`, 16, number of row interfaces
- `NCOL`, 16, number of column interfaces
- `TS_W`, 16, timestamp counter width
- `DEPTH`, 4, FIFO depth in events (power of 2, ≥2)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset; one clock domain (`clk`)
- `aer_dis`  in  1  1 = ignore new events (FIFO still drains)
- `row_s`  in  NROW  `s` outputs of the row interfaces, asynchronous, nominally one-hot
- `col_s`  in  NCOL  `s` outputs of the column interfaces, asynchronous, nominally one-hot
- `arbtop_n_ri`  out  1  active-low hold-off to the interfaces; 0 = encoder busy with the current event
- `aer_req`  out  1  off-chip request, 4-phase
- `aer_ack`  in  1  off-chip acknowledge, asynchronous
- `aer_row`  out  clog2(NROW)  row address of the head event
- `aer_col`  out  clog2(NCOL)  column address of the head event
- `aer_ts`  out  TS_W  timestamp of the head event
- `drop_cnt`  out  8  events lost because the FIFO was full; saturating
- `err_cnt`  out  8  multi-hot captures; saturating

## Operation
- `row_s`, `col_s` and `aer_ack` each pass through a 2-flop synchronizer. All logic below uses the synchronized versions.
- `ts` is a free-running TS_W counter. It increments every cycle and wraps from all-ones to 0.
- Capture FSM states: `C_IDLE`, `C_CAPT`, `C_REL`.
  - `C_IDLE`: exits when `aer_dis`=0, the synced row and column vectors are both non-zero, and both are equal to their values on the previous cycle (stable). Goes to `C_CAPT`.
  - `C_CAPT`: one cycle, then always goes to `C_REL`.
    - If both vectors are exactly one-hot: encode and push {row, col, ts}. If the FIFO is full, drop the event and increment `drop_cnt` instead.
    - If either vector is multi-hot: increment `err_cnt`; no push.
  - `C_REL`: stays until the synced `row_s` and `col_s` are both all-zero, then goes to `C_IDLE`.
- `arbtop_n_ri` = 0 in `C_CAPT` and `C_REL`, 1 in `C_IDLE`. It is registered.
- Output FSM states: `O_IDLE`, `O_REQ`, `O_WAIT`.
  - `O_IDLE`: if the FIFO is non-empty, go to `O_REQ`.
  - `O_REQ`: `aer_req`=1; on synced `aer_ack`=1, go to `O_WAIT`.
  - `O_WAIT`: `aer_req`=0; on synced `aer_ack`=0, pop and go to `O_IDLE`.
- `aer_row`, `aer_col` and `aer_ts` always show the FIFO head. They are held stable from `aer_req` rise until the pop.
- A push and a pop in the same cycle are both performed, so the level is unchanged. A full FIFO with a pop in the same cycle accepts the push.
- `aer_dis`=1 mid-event: the capture in progress completes, including `C_REL`. Only new entries into `C_CAPT` are blocked.

## Timing
- Reset values: `arbtop_n_ri`=1, `aer_req`=0, `aer_row`/`aer_col`/`aer_ts`=0, `drop_cnt`/`err_cnt`=0. Both FSMs idle, FIFO empty, `ts`=0, synchronizers cleared.
- Latency, with edge 0 = first edge that samples both vectors stable:
  - synced vectors valid after edge 1;
  - stability check passes after edge 2;
  - push and `arbtop_n_ri`=0 at edge 3;
  - `aer_req`=1 at edge 4 if the FIFO was empty and the output FSM was idle.
- The captured timestamp is the `ts` value at the push edge.
- `arbtop_n_ri` returns to 1 one edge after the synced vectors read all-zero, i.e. 3 edges after the raw inputs clear.
- Minimum event spacing is 6 cycles plus the time the interfaces take to clear.
- Off-chip handshake: each phase costs 2 synchronizer cycles plus 1 FSM cycle. `aer_req` never toggles while `aer_ack` (synced) disagrees with the expected phase.
- `rst` mid-handshake: `aer_req` drops asynchronously and the FIFO contents are discarded. The receiver must tolerate `aer_req` falling before `aer_ack`.
- Counters saturate at 255 and do not wrap.

## Structure
- Package `aer_pkg`: capture and output state enums, the `ROW_AW`/`COL_AW` width functions, and a packed event struct {row, col, ts}.
- Sub-module `aer_fifo`: synchronous FIFO with parameterized DEPTH and width, outputs `full`/`empty`, head shown without a read cycle (show-ahead).
- Synchronizers and the one-hot encode/check stay inline.

## Test plan
- Single event `row_s`=0x0010, `col_s`=0x0200 held until `arbtop_n_ri` falls, then cleared; ack is answered. Expect `aer_row`=4, `aer_col`=9, one `aer_req` pulse, and `arbtop_n_ri` back to 1.
- Multi-hot `row_s`=0x0011: expect `err_cnt`=1, no `aer_req`, and the `arbtop_n_ri` low/high cycle still completes.
- Receiver holds `aer_ack`=0 and 6 events are sent with DEPTH=4. Expect `drop_cnt`=2. After the receiver releases, exactly 4 events come out in order, with increasing timestamps.
- `aer_dis`=1 with an event applied: expect `arbtop_n_ri` to stay 1 and the FIFO to stay empty. Buffered events already in the FIFO still drain.
- `rst` asserted while `aer_req`=1: expect `aer_req`=0 immediately, FIFO empty, counters 0, and a clean first event after reset is released.
- `ts` wrap with TS_W=4: events 20 cycles apart. Expect the timestamp difference to be (20 mod 16) = 4.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared types for the AER event encoder: FSM state enums, address-width helpers
// and the event record for the default 16x16 array with a 16-bit timestamp.
package aer_pkg;

  typedef enum logic [1:0] {
    C_IDLE,
    C_CAPT,
    C_REL
  } cap_state_e;

  typedef enum logic [1:0] {
    O_IDLE,
    O_REQ,
    O_WAIT
  } out_state_e;

  localparam int unsigned AER_NROW_DEF = 16;
  localparam int unsigned AER_NCOL_DEF = 16;
  localparam int unsigned AER_TS_W_DEF = 16;

  function automatic int unsigned ROW_AW(input int unsigned nrow);
    return (nrow > 1) ? $clog2(nrow) : 1;
  endfunction

  function automatic int unsigned COL_AW(input int unsigned ncol);
    return (ncol > 1) ? $clog2(ncol) : 1;
  endfunction

  // Other parameterisations build a local struct with the same field order.
  typedef struct packed {
    logic [ROW_AW(AER_NROW_DEF)-1:0] row;
    logic [COL_AW(AER_NCOL_DEF)-1:0] col;
    logic [AER_TS_W_DEF-1:0]         ts;
  } aer_evt_t;

endpackage

// File: rtl/aer_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module aer_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q;
  logic [PW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q[PW-1:0]] <= wdata_i;
        wr_q                <= wr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_q <= rd_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/aer_event_encoder.sv
// Encodes row/column acknowledge vectors into timestamped AER events, buffers them
// and drives a 4-phase req/ack handshake to the off-chip receiver.
module aer_event_encoder
  import aer_pkg::*;
#(
  parameter int unsigned NROW  = 16,
  parameter int unsigned NCOL  = 16,
  parameter int unsigned TS_W  = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      aer_dis,
  input  logic [NROW-1:0]           row_s,
  input  logic [NCOL-1:0]           col_s,
  output logic                      arbtop_n_ri,
  output logic                      aer_req,
  input  logic                      aer_ack,
  output logic [ROW_AW(NROW)-1:0]   aer_row,
  output logic [COL_AW(NCOL)-1:0]   aer_col,
  output logic [TS_W-1:0]           aer_ts,
  output logic [7:0]                drop_cnt,
  output logic [7:0]                err_cnt
);

  localparam int unsigned RAW = ROW_AW(NROW);
  localparam int unsigned CAW = COL_AW(NCOL);

  typedef struct packed {
    logic [RAW-1:0]  row;
    logic [CAW-1:0]  col;
    logic [TS_W-1:0] ts;
  } evt_t;

  logic [NROW-1:0] row_m_q, row_s_q, row_p_q;
  logic [NCOL-1:0] col_m_q, col_s_q, col_p_q;
  logic            ack_m_q, ack_s_q;
  logic [TS_W-1:0] ts_q;
  logic            arb_q;
  logic [7:0]      drop_q, err_q;

  cap_state_e cap_q, cap_d;
  out_state_e out_q, out_d;

  logic           start;
  logic           onehot_ok;
  logic           cap_push, cap_err, cap_drop;
  logic           pop;
  logic [RAW-1:0] row_idx;
  logic [CAW-1:0] col_idx;
  evt_t           wr_evt, head_evt;
  logic           fifo_full, fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m_q <= '0;
      row_s_q <= '0;
      row_p_q <= '0;
      col_m_q <= '0;
      col_s_q <= '0;
      col_p_q <= '0;
      ack_m_q <= 1'b0;
      ack_s_q <= 1'b0;
      ts_q    <= '0;
    end else begin
      row_m_q <= row_s;
      row_s_q <= row_m_q;
      row_p_q <= row_s_q;
      col_m_q <= col_s;
      col_s_q <= col_m_q;
      col_p_q <= col_s_q;
      ack_m_q <= aer_ack;
      ack_s_q <= ack_m_q;
      ts_q    <= ts_q + TS_W'(1);
    end
  end

  always_comb begin
    row_idx = '0;
    for (int unsigned i = 0; i < NROW; i++) begin
      if (row_s_q[i]) row_idx = RAW'(i);
    end
    col_idx = '0;
    for (int unsigned i = 0; i < NCOL; i++) begin
      if (col_s_q[i]) col_idx = CAW'(i);
    end
  end

  assign start = (cap_q == C_IDLE) && !aer_dis && (|row_s_q) && (|col_s_q) &&
                 (row_s_q == row_p_q) && (col_s_q == col_p_q);
  assign onehot_ok = $onehot(row_s_q) && $onehot(col_s_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cap_q <= C_IDLE;
    else     cap_q <= cap_d;
  end

  always_comb begin
    cap_d = cap_q;
    case (cap_q)
      C_IDLE:  if (start) cap_d = C_CAPT;
      C_CAPT:  cap_d = C_REL;
      C_REL:   if (!(|row_s_q) && !(|col_s_q)) cap_d = C_IDLE;
      default: cap_d = C_IDLE;
    endcase
  end

  // Capture actions commit on the edge that enters C_CAPT, so the push lands
  // together with the falling hold-off and the timestamp is the pre-edge count.
  always_comb begin
    cap_push = 1'b0;
    cap_err  = 1'b0;
    cap_drop = 1'b0;
    if (start) begin
      cap_push = onehot_ok;
      cap_err  = !onehot_ok;
      cap_drop = onehot_ok && fifo_full && !pop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_q  <= 1'b1;
      drop_q <= '0;
      err_q  <= '0;
    end else begin
      arb_q <= (cap_d == C_IDLE);
      if (cap_drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      if (cap_err && (err_q != 8'hFF))   err_q  <= err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= O_IDLE;
    else     out_q <= out_d;
  end

  always_comb begin
    out_d = out_q;
    case (out_q)
      O_IDLE:  if (!fifo_empty) out_d = O_REQ;
      O_REQ:   if (ack_s_q) out_d = O_WAIT;
      O_WAIT:  if (!ack_s_q) out_d = O_IDLE;
      default: out_d = O_IDLE;
    endcase
  end

  always_comb begin
    aer_req = (out_q == O_REQ);
    pop     = (out_q == O_WAIT) && !ack_s_q;
  end

  assign wr_evt = '{row: row_idx, col: col_idx, ts: ts_q};

  aer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(evt_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cap_push),
    .pop_i   (pop),
    .wdata_i (wr_evt),
    .rdata_o (head_evt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign aer_row     = head_evt.row;
  assign aer_col     = head_evt.col;
  assign aer_ts      = head_evt.ts;
  assign arbtop_n_ri = arb_q;
  assign drop_cnt    = drop_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_aer_event_encoder.sv
// Bench for aer_event_encoder: queue-based reference model of the event stream,
// plus a second instance with a 4-bit timestamp for the wrap check.
module tb_aer_event_encoder;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        aer_dis;
  logic [15:0] row_s, col_s;
  logic        ack_a;
  logic        arb_a, req_a, arb_b, req_b, ack_b;
  logic [3:0]  row_a, col_a, row_b, col_b;
  logic [15:0] ts_a;
  logic [3:0]  ts_b;
  logic [7:0]  drop_a, err_a, drop_b, err_b;

  always #5 clk = ~clk;

  aer_event_encoder #(.NROW(16), .NCOL(16), .TS_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .aer_dis(aer_dis), .row_s(row_s), .col_s(col_s),
    .arbtop_n_ri(arb_a), .aer_req(req_a), .aer_ack(ack_a),
    .aer_row(row_a), .aer_col(col_a), .aer_ts(ts_a),
    .drop_cnt(drop_a), .err_cnt(err_a)
  );

  aer_event_encoder #(.NROW(16), .NCOL(16), .TS_W(4), .DEPTH(DEPTH)) dut_ts4 (
    .clk(clk), .rst(rst), .aer_dis(aer_dis), .row_s(row_s), .col_s(col_s),
    .arbtop_n_ri(arb_b), .aer_req(req_b), .aer_ack(ack_b),
    .aer_row(row_b), .aer_col(col_b), .aer_ts(ts_b),
    .drop_cnt(drop_b), .err_cnt(err_b)
  );

  // Always-ready receiver for the narrow-timestamp instance.
  assign ack_b = req_b;

  typedef struct {
    int unsigned row;
    int unsigned col;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned exp_drop, exp_err, exp_push;
  int unsigned got_ts[$];
  int unsigned tsb_q[$];
  int unsigned req_rises;
  logic        req_a_d, req_b_d;
  int unsigned checks = 0, errors = 0;

  always @(negedge clk) begin
    if (req_a === 1'b1 && req_a_d !== 1'b1) req_rises++;
    req_a_d = req_a;
    if (req_b === 1'b1 && req_b_d !== 1'b1) tsb_q.push_back(int'(ts_b));
    req_b_d = req_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned idx_of(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Applies one raw event, updates the model, then releases it after the hold-off.
  task automatic send_event(input logic [15:0] rv, input logic [15:0] cv);
    int unsigned n;
    ev_t e;
    @(negedge clk);
    row_s = rv;
    col_s = cv;
    n = 0;
    while (arb_a !== 1'b0 && n < 30) begin @(negedge clk); n++; end
    check("arb_fall", arb_a, 0);
    if ($countones(rv) == 1 && $countones(cv) == 1) begin
      e.row = idx_of(rv);
      e.col = idx_of(cv);
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(e);
        exp_push++;
      end else if (exp_drop < 255) exp_drop++;
    end else if (exp_err < 255) exp_err++;
    row_s = '0;
    col_s = '0;
    n = 0;
    while (arb_a !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    check("arb_rise", arb_a, 1);
  endtask

  // Receiver side: completes n handshakes, checking each head against the model.
  task automatic respond(input int unsigned count);
    int unsigned n;
    ev_t e;
    for (int unsigned k = 0; k < count; k++) begin
      n = 0;
      while (req_a !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      check("req_rise", req_a, 1);
      check("model_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin e.row = 0; e.col = 0; end
      check("head_row", row_a, e.row);
      check("head_col", col_a, e.col);
      got_ts.push_back(int'(ts_a));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack_a = 1'b1;
      n = 0;
      while (req_a !== 1'b0 && n < 40) begin @(negedge clk); n++; end
      check("req_fall", req_a, 0);
      check("hold_col", col_a, e.col);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack_a = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, lows, n, r, c, pushes;
    logic [15:0] rv, cv;

    rst = 1'b1; aer_dis = 1'b0; row_s = '0; col_s = '0; ack_a = 1'b0;
    exp_drop = 0; exp_err = 0; exp_push = 0;
    repeat (3) @(negedge clk);
    check("rst_arb", arb_a, 1);
    check("rst_req", req_a, 0);
    check("rst_row", row_a, 0);
    check("rst_col", col_a, 0);
    check("rst_ts", ts_a, 0);
    check("rst_drop", drop_a, 0);
    check("rst_err", err_a, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    base = req_rises;
    send_event(16'h0010, 16'h0200);
    respond(1);
    repeat (10) @(negedge clk);
    check("single_pulses", req_rises - base, 1);
    check("single_arb", arb_a, 1);

    base = req_rises;
    send_event(16'h0011, 16'h0200);
    repeat (12) @(negedge clk);
    check("multihot_err", err_a, exp_err);
    check("multihot_noreq", req_rises - base, 0);

    // Receiver stalled: six events into a four-deep buffer.
    base = req_rises;
    got_ts.delete();
    for (int i = 0; i < 6; i++) begin
      send_event(16'(1) << $urandom_range(0, 15), 16'(1) << $urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check("ovf_drop", drop_a, exp_drop);
    respond(4);
    for (int i = 1; i < 4; i++) check("ovf_ts_order", got_ts[i] > got_ts[i-1], 1);
    repeat (20) @(negedge clk);
    check("ovf_count", req_rises - base, 4);

    // Disabled capture with two events already buffered.
    base = req_rises;
    send_event(16'(1) << $urandom_range(0, 15), 16'(1) << $urandom_range(0, 15));
    send_event(16'(1) << $urandom_range(0, 15), 16'(1) << $urandom_range(0, 15));
    aer_dis = 1'b1;
    @(negedge clk);
    row_s = 16'h0100; col_s = 16'h0004;
    lows = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (arb_a !== 1'b1) lows++; end
    row_s = '0; col_s = '0;
    check("dis_arb_held", lows, 0);
    respond(2);
    repeat (20) @(negedge clk);
    check("dis_drain_count", req_rises - base, 2);
    aer_dis = 1'b0;

    // Reset during an open handshake.
    send_event(16'h0002, 16'h8000);
    n = 0;
    while (req_a !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("prerst_req", req_a, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_req", req_a, 0);
    check("midrst_drop", drop_a, 0);
    check("midrst_err", err_a, 0);
    check("midrst_arb", arb_a, 1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); exp_drop = 0; exp_err = 0;
    @(negedge clk);
    check("postrst_row", row_a, 0);
    check("postrst_req", req_a, 0);
    send_event(16'(1) << $urandom_range(0, 15), 16'(1) << $urandom_range(0, 15));
    respond(1);

    // Randomized traffic with occasional multi-hot captures.
    base = req_rises;
    pushes = exp_push;
    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(0, 15);
      c = $urandom_range(0, 15);
      rv = 16'(1) << r;
      cv = 16'(1) << c;
      if ($urandom_range(0, 3) == 0) rv = rv | (16'(1) << ((r + 1 + $urandom_range(0, 14)) % 16));
      n = exp_push;
      send_event(rv, cv);
      if (exp_push != n) respond(1);
      repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("rand_err", err_a, exp_err);
    check("rand_drop", drop_a, exp_drop);
    check("rand_count", req_rises - base, exp_push - pushes);

    // Two events 20 cycles apart; narrow-timestamp copy must wrap.
    got_ts.delete();
    tsb_q.delete();
    n = 20;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rv = 16'(1) << $urandom_range(0, 15);
      cv = 16'(1) << $urandom_range(0, 15);
      row_s = rv; col_s = cv;
      exp_q.push_back('{row: idx_of(rv), col: idx_of(cv)});
      repeat (8) @(negedge clk);
      row_s = '0; col_s = '0;
      repeat (n - 9) @(negedge clk);
    end
    respond(2);
    repeat (10) @(negedge clk);
    check("ts_diff_16", (got_ts[1] - got_ts[0]) & 32'hFFFF, n);
    check("ts4_events", tsb_q.size(), 2);
    if (tsb_q.size() == 2) check("ts_diff_4", (tsb_q[1] - tsb_q[0]) & 32'hF, n % 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
